sub_bytes_iter: RTL and testbench
=================================

Name: sub_bytes_iter

Overview:
- Iterative AES SubBytes stage. It replaces each of the 16 state bytes with its S-box value, LANES bytes per cycle.
- Uses synchronous (registered) S-box lookups so the tables map to block RAM.
- Sits directly upstream of shift_rows in the round datapath; its state_out feeds shift_rows.state_in.
- Valid/ready handshake on input and output lets the round controller stall it.

Parameters:
- LANES, 4, S-box lookups per cycle. Legal values: 1, 2, 4, 8, 16. G = 16/LANES groups.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  state_in valid
- in_ready  output  1  block can accept a state
- state_in  input  128  input state; byte i = state_in[8i+7:8i], column-major (byte 0 = row 0 col 0, byte 1 = row 1 col 0, ...)
- out_valid  output  1  state_out holds a completed result
- out_ready  input  1  downstream accepts the result
- state_out  output  128  substituted state, same byte layout as state_in

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state = IDLE; out_valid = 0; state_out = 0; group counters = 0.
  - in_ready = 0 while reset_n low.
- FSM states: IDLE, LOOKUP, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: capture state_in into the work register, clear cnt, go to LOOKUP.
  - state_in is sampled only on the handshake edge.
- LOOKUP:
  - in_ready = 0.
  - Each cycle, present work bytes cnt*LANES .. cnt*LANES+LANES-1 to the LANES sbox_sync instances; cnt increments.
  - The write pointer is cnt delayed one cycle, with a valid bit. The S-box output for group g is written into the result register at the edge after the S-box registers it (pipelined: issue of group g overlaps write of group g-1).
  - After the last group is written, go to DONE and assert out_valid.
- Latency: handshake edge E0 -> out_valid high after edge E0+G+1. LANES=4 gives 5 cycles; LANES=1 gives 17; LANES=16 gives 2.
- DONE:
  - out_valid = 1.
  - state_out holds stable while out_ready is low, for any duration.
  - On out_ready: out_valid drops next edge, state goes to IDLE.
  - in_ready is 0 during DONE, so there is one bubble cycle between output handshake and next accept. No chaining.
- state_out is driven only from the result register; it never exposes a partially written state.
- Counter: cnt width = clog2(G), minimum 1 bit. It stops at G-1; no wrap into stale groups.
- in_valid in LOOKUP/DONE is ignored. Upstream holds it until in_ready.
- out_ready outside DONE is ignored.
- Reset mid-LOOKUP or mid-DONE aborts immediately. The result is discarded; state_out = 0 and out_valid = 0 asynchronously.

Optional Feature:
- Macro: SUB_BYTES_INV_EN.
- Defined:
  - Extra input port inv (1 bit), sampled with state_in at the input handshake and held for that operation.
  - inv = 1 selects the InvSubBytes table. Each lane instantiates a second sbox_sync loaded with INV_SBOX; a registered mux selects between them.
  - Latency unchanged.
- Undefined: no inv port, forward table only, no inverse ROMs synthesised.

Decomposition:
- Package aes_pkg:
  - SBOX and INV_SBOX, 256x8 constant arrays.
  - NUM_BYTES = 16.
  - typedef enum sub_state_t {IDLE, LOOKUP, DONE}.
  - typedef logic [7:0] byte_t.
- Sub-module sbox_sync: inputs clk, a[7:0]; output y[7:0]. One-cycle registered lookup of SBOX, no reset on y. The INV variant is selected by a parameter on sbox_sync.
- The top module contains the FSM, counters, work and result registers, and the LANES-wide generate of sbox_sync.

Test Plan:
- FIPS-197 App. B round 1, LANES=4: state_in = 128'h0848f8e9_2a8dc69a_2be2f4a0_bee33d19 -> state_out = 128'h3052411e_e55db4b8_f198bfe0_ae1127d4. out_valid rises exactly 5 cycles after the accept edge.
- All-zero input -> 128'h6363...63. Then all-0x53 input -> all 0xed. Back-to-back, out_ready tied 1: in_ready returns high exactly 1 cycle after the output handshake.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE -> state_out and out_valid stable, in_ready = 0 throughout. Release -> out_valid low next edge, IDLE.
- Reset mid-LOOKUP (assert reset_n = 0 two cycles after accept) -> out_valid = 0, state_out = 0, FSM IDLE. Then a fresh App. B vector completes correctly.
- Parameter sweep LANES = 1, 16 on the App. B vector -> identical state_out; latency 17 and 2 cycles respectively.
- SUB_BYTES_INV_EN defined, inv = 1: input all-0x63 -> all 0x00. Also the App. B output vector -> the App. B input vector.

Source files
------------

// File: rtl/sub_bytes_iter_pkg.sv
// Shared AES SubBytes definitions: forward/inverse S-box tables, byte type and FSM states.
package aes_pkg;

    localparam int NUM_BYTES = 16;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        DONE   = 2'd2
    } sub_state_t;

    // Ascending packed range so SBOX[x] is the entry for input byte x.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

endpackage

// File: rtl/sub_bytes_iter_if.sv
// Valid/ready bus of sub_bytes_iter; inv exists only when SUB_BYTES_INV_EN is defined.
interface sub_bytes_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
`ifdef SUB_BYTES_INV_EN
    logic         inv;

    modport master (output in_valid, state_in, out_ready, inv,
                    input  in_ready, out_valid, state_out);
    modport slave  (input  in_valid, state_in, out_ready, inv,
                    output in_ready, out_valid, state_out);
`else
    modport master (output in_valid, state_in, out_ready,
                    input  in_ready, out_valid, state_out);
    modport slave  (input  in_valid, state_in, out_ready,
                    output in_ready, out_valid, state_out);
`endif
endinterface

// File: rtl/sub_bytes_iter_sbox_sync.sv
// One-cycle registered S-box lookup (no reset so the table can map onto block RAM).
module sbox_sync
    import aes_pkg::*;
#(
    parameter bit INV = 1'b0
) (
    input  logic  clk,
    input  byte_t a,
    output byte_t y
);

    // Registered table read; INV is an elaboration constant so only one table is built.
    always_ff @(posedge clk) begin
        if (INV) begin
            y <= INV_SBOX[a];
        end else begin
            y <= SBOX[a];
        end
    end

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes, LANES bytes per cycle through registered S-boxes.
// Optional macro SUB_BYTES_INV_EN adds an inv bus bit selecting InvSubBytes.
module sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    sub_bytes_iter_if.slave  bus
);

    localparam int               G       = NUM_BYTES / LANES;
    localparam int               CW      = (G > 1) ? $clog2(G) : 1;
    localparam logic [CW-1:0]    CNT_MAX = CW'(G - 1);

    sub_state_t                  r_state;
    sub_state_t                  w_next;
    logic [CW-1:0]               r_cnt;
    logic [CW-1:0]               r_wr_ptr;
    logic                        r_wr_valid;
    byte_t [NUM_BYTES-1:0]       r_work;
    byte_t [NUM_BYTES-1:0]       r_result;
    logic                        w_accept;
    logic                        w_last_wr;
    logic [3:0]                  w_rd_base;
    logic [3:0]                  w_wr_base;
    byte_t                       w_sbox_a [LANES];
    byte_t                       w_sbox_y [LANES];
`ifdef SUB_BYTES_INV_EN
    logic                        r_inv;
`endif

    assign w_accept  = bus.in_valid && (r_state == IDLE);
    assign w_last_wr = r_wr_valid && (r_wr_ptr == CNT_MAX);
    assign w_rd_base = 4'(int'(r_cnt) * LANES);
    assign w_wr_base = 4'(int'(r_wr_ptr) * LANES);

    // Handshake outputs come straight from state; result is hidden until complete.
    assign bus.in_ready  = reset_n && (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.state_out = (r_state == DONE) ? r_result : 128'd0;

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next = LOOKUP;
                else          w_next = IDLE;
            end
            LOOKUP: begin
                if (w_last_wr) w_next = DONE;
                else           w_next = LOOKUP;
            end
            DONE: begin
                if (bus.out_ready) w_next = IDLE;
                else               w_next = DONE;
            end
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Issue counter (saturating) and its one-cycle-delayed write pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_wr_ptr   <= '0;
            r_wr_valid <= 1'b0;
        end else begin
            r_wr_ptr   <= r_cnt;
            r_wr_valid <= (r_state == LOOKUP) && !w_last_wr;
            if (w_accept) begin
                r_cnt <= '0;
            end else if ((r_state == LOOKUP) && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Work capture on accept; result bytes land one group per cycle behind the issue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_work   <= '0;
            r_result <= '0;
`ifdef SUB_BYTES_INV_EN
            r_inv    <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_work <= bus.state_in;
`ifdef SUB_BYTES_INV_EN
                r_inv  <= bus.inv;
`endif
            end
            if (r_wr_valid) begin
                for (int l = 0; l < LANES; l++) begin
                    r_result[w_wr_base + 4'(l)] <= w_sbox_y[l];
                end
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_sbox_a[l] = r_work[w_rd_base + 4'(l)];
`ifdef SUB_BYTES_INV_EN
        byte_t w_fwd_y;
        byte_t w_inv_y;
        sbox_sync #(.INV(1'b0)) u_fwd (.clk(clk), .a(w_sbox_a[l]), .y(w_fwd_y));
        sbox_sync #(.INV(1'b1)) u_inv (.clk(clk), .a(w_sbox_a[l]), .y(w_inv_y));
        // r_inv is held for the whole operation, so selecting after the registers is safe.
        assign w_sbox_y[l] = r_inv ? w_inv_y : w_fwd_y;
`else
        sbox_sync #(.INV(1'b0)) u_fwd (.clk(clk), .a(w_sbox_a[l]), .y(w_sbox_y[l]));
`endif
    end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Randomized bench for sub_bytes_iter: S-box model derived from GF(2^8) arithmetic,
// timing model expressed as accept-cycle + (16/LANES + 1).
module tb_sub_bytes_iter;

    localparam logic [127:0] B_IN  = 128'h0848f8e9_2a8dc69a_2be2f4a0_bee33d19;
    localparam logic [127:0] B_OUT = 128'h3052411e_e55db4b8_f198bfe0_ae1127d4;
    localparam int           LAT4  = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    logic         rand_mode = 1'b0;
    logic         ordy_cmd  = 1'b1;
    logic         sw_valid  = 1'b0;
    logic [127:0] sw_data   = 128'd0;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    sub_bytes_iter_if bus ();
    sub_bytes_iter_if bus1 ();
    sub_bytes_iter_if bus16 ();

    sub_bytes_iter #(.LANES(4))  u_dut   (.clk(clk), .reset_n(rst_n), .bus(bus));
    sub_bytes_iter #(.LANES(1))  u_dut1  (.clk(clk), .reset_n(rst_n), .bus(bus1));
    sub_bytes_iter #(.LANES(16)) u_dut16 (.clk(clk), .reset_n(rst_n), .bus(bus16));

    assign bus1.in_valid   = sw_valid;
    assign bus1.state_in   = sw_data;
    assign bus1.out_ready  = 1'b1;
    assign bus16.in_valid  = sw_valid;
    assign bus16.state_in  = sw_data;
    assign bus16.out_ready = 1'b1;
`ifdef SUB_BYTES_INV_EN
    assign bus1.inv  = 1'b0;
    assign bus16.inv = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    always @(posedge clk) begin
        #1;
        bus.out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ordy_cmd;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'd0;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} >> (8 - n);
        return t[7:0];
    endfunction

    function automatic logic [127:0] model_sub(input logic [127:0] d, input logic iv);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = iv ? inv_tab[d[8*i +: 8]] : fwd_tab[d[8*i +: 8]];
        end
        return r;
    endfunction

    // Timing/data reference for the LANES=4 instance, checked every cycle.
    logic         m_busy = 1'b0;
    int           m_acc  = 0;
    logic [127:0] m_exp  = 128'd0;
    logic         m_iv;
    logic         exp_ov;
    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            chk("rst_in_ready",  128'(bus.in_ready),  128'd0);
            chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
            chk("rst_state_out", bus.state_out,        128'd0);
        end else begin
            exp_ov = m_busy && (cyc >= m_acc + LAT4);
            chk("in_ready",  128'(bus.in_ready),  128'(!m_busy));
            chk("out_valid", 128'(bus.out_valid), 128'(exp_ov));
            if (exp_ov) chk("state_out", bus.state_out, m_exp);
            if (!m_busy && bus.in_valid) begin
`ifdef SUB_BYTES_INV_EN
                m_iv = bus.inv;
`else
                m_iv = 1'b0;
`endif
                m_busy = 1'b1;
                m_acc  = cyc + 1;
                m_exp  = model_sub(bus.state_in, m_iv);
            end else if (exp_ov && bus.out_ready) begin
                m_busy = 1'b0;
            end
        end
    end

    task automatic send(input logic [127:0] d, input logic iv, output int acc);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.state_in = d;
`ifdef SUB_BYTES_INV_EN
        bus.inv = iv;
`endif
        acc = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                acc = cyc + 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.state_in = {$urandom(), $urandom(), $urandom(), $urandom()};
`ifdef SUB_BYTES_INV_EN
        bus.inv = 1'($urandom_range(0, 1));
`endif
        if (acc < 0) chk("send_timeout", 128'd1, 128'd0);
    endtask

    task automatic expect_out(input logic [127:0] exp, input int acc, input string name);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                chk({name, "_data"}, bus.state_out, exp);
                chk({name, "_latency"}, 128'(cyc - acc), 128'(LAT4));
                return;
            end
        end
        chk({name, "_timeout"}, 128'd1, 128'd0);
    endtask

    initial begin
        int           acc;
        int           lat1;
        int           lat16;
        logic [127:0] d;
        logic [127:0] d1;
        logic [127:0] d16;
        logic [7:0]   z;
        logic [7:0]   s;

        bus.in_valid = 1'b0;
        bus.state_in = 128'd0;
`ifdef SUB_BYTES_INV_EN
        bus.inv = 1'b0;
`endif
        // Build tables from the field definition: multiplicative inverse then affine map.
        for (int x = 0; x < 256; x++) begin
            z = 8'd0;
            for (int c = 1; c < 256; c++) begin
                if (gmul(8'(x), 8'(c)) == 8'd1) z = 8'(c);
            end
            s = z ^ rotl(z, 1) ^ rotl(z, 2) ^ rotl(z, 3) ^ rotl(z, 4) ^ 8'h63;
            fwd_tab[x] = s;
            inv_tab[s] = 8'(x);
        end
        chk("model_sbox_00",  128'(fwd_tab[0]),    128'h63);
        chk("model_sbox_53",  128'(fwd_tab[83]),   128'hed);
        chk("model_inv_63",   128'(inv_tab[99]),   128'h00);
        chk("model_app_b",    model_sub(B_IN, 1'b0), B_OUT);

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", 128'(bus.in_ready), 128'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // App. B vector with literal expectation.
        send(B_IN, 1'b0, acc);
        expect_out(B_OUT, acc, "app_b");

        // All-zero then all-0x53 back to back; in_ready must return right after output handshake.
        send(128'd0, 1'b0, acc);
        expect_out({16{8'h63}}, acc, "zero");
        @(negedge clk);
        chk("bubble_in_ready",  128'(bus.in_ready),  128'd1);
        chk("bubble_out_valid", 128'(bus.out_valid), 128'd0);
        send({16{8'h53}}, 1'b0, acc);
        expect_out({16{8'hed}}, acc, "all53");

        // Backpressure: hold result for 10 cycles.
        ordy_cmd = 1'b0;
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(d, 1'b0, acc);
        expect_out(model_sub(d, 1'b0), acc, "bp");
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_out_valid", 128'(bus.out_valid), 128'd1);
            chk("bp_state_out", bus.state_out,        model_sub(d, 1'b0));
            chk("bp_in_ready",  128'(bus.in_ready),  128'd0);
        end
        ordy_cmd = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_out_valid", 128'(bus.out_valid), 128'd0);
        chk("bp_release_in_ready",  128'(bus.in_ready),  128'd1);

        // Reset two cycles into LOOKUP, then a fresh vector.
        send(B_IN, 1'b0, acc);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", 128'(bus.out_valid), 128'd0);
        chk("abort_state_out", bus.state_out,        128'd0);
        chk("abort_in_ready",  128'(bus.in_ready),  128'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_idle", 128'(bus.in_ready), 128'd1);
        send(B_IN, 1'b0, acc);
        expect_out(B_OUT, acc, "after_abort");

`ifdef SUB_BYTES_INV_EN
        send({16{8'h63}}, 1'b1, acc);
        expect_out(128'd0, acc, "inv_63");
        send(B_OUT, 1'b1, acc);
        expect_out(B_IN, acc, "inv_app_b");
`endif

        // Random traffic with random backpressure; the per-cycle compare does the checking.
        rand_mode = 1'b1;
        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            send({$urandom(), $urandom(), $urandom(), $urandom()}, 1'($urandom_range(0, 1)), acc);
        end
        rand_mode = 1'b0;
        ordy_cmd  = 1'b1;
        repeat (30) @(posedge clk);

        // LANES sweep on the App. B vector.
        @(posedge clk);
        #1;
        sw_valid = 1'b1;
        sw_data  = B_IN;
        @(negedge clk);
        chk("sweep1_in_ready",  128'(bus1.in_ready),  128'd1);
        chk("sweep16_in_ready", 128'(bus16.in_ready), 128'd1);
        acc = cyc + 1;
        @(posedge clk);
        #1;
        sw_valid = 1'b0;
        sw_data  = 128'd0;
        lat1 = -1;
        lat16 = -1;
        d1 = 128'd0;
        d16 = 128'd0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (lat1 < 0 && bus1.out_valid) begin
                lat1 = cyc - acc;
                d1 = bus1.state_out;
            end
            if (lat16 < 0 && bus16.out_valid) begin
                lat16 = cyc - acc;
                d16 = bus16.state_out;
            end
        end
        chk("lanes1_data",     d1,           B_OUT);
        chk("lanes1_latency",  128'(lat1),   128'd17);
        chk("lanes16_data",    d16,          B_OUT);
        chk("lanes16_latency", 128'(lat16),  128'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
